// File: rtl/wash_pkg.sv
// Shared phase type, per-mode timing/level tables and 7-segment decode for wash_seq.
package wash_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FILL   = 4'd1,
    WASH   = 4'd2,
    DRAIN  = 4'd3,
    RFILL  = 4'd4,
    RINSE  = 4'd5,
    RDRAIN = 4'd6,
    SPIN   = 4'd7,
    DONE   = 4'd8
  } phase_t;

  localparam int unsigned SEC_W = 4;
  localparam int unsigned LVL_W = 8;
  localparam logic [3:0]  BLANK_CODE = 4'hF;

  // Indexed by mode: 0=dry-only, 1=small, 2=medium, 3=big.
  localparam logic [3:0][SEC_W-1:0] LEVEL_S = {4'd8,  4'd5, 4'd3, 4'd0};
  localparam logic [3:0][SEC_W-1:0] WASH_S  = {4'd12, 4'd9, 4'd6, 4'd0};
  localparam logic [3:0][SEC_W-1:0] RINSE_S = {4'd8,  4'd6, 4'd4, 4'd0};
  localparam logic [3:0][SEC_W-1:0] SPIN_S  = {4'd8,  4'd6, 4'd4, 4'd5};

  function automatic logic [SEC_W-1:0] phase_secs(input phase_t p, input logic [1:0] m);
    case (p)
      FILL, DRAIN, RFILL, RDRAIN: phase_secs = LEVEL_S[m];
      WASH:                       phase_secs = WASH_S[m];
      RINSE:                      phase_secs = RINSE_S[m];
      SPIN:                       phase_secs = SPIN_S[m];
      default:                    phase_secs = '0;
    endcase
  endfunction

  // First phase at or after start with a non-zero duration; DONE if none remain.
  function automatic phase_t first_live(input phase_t start, input logic [1:0] m);
    first_live = DONE;
    for (int i = int'(SPIN); i >= int'(FILL); i--) begin
      if ((4'(i) >= 4'(start)) && (phase_secs(phase_t'(4'(i)), m) != '0)) begin
        first_live = phase_t'(4'(i));
      end
    end
  endfunction

  function automatic logic [7:0] phase_light(input phase_t p);
    if (p == IDLE) phase_light = '0;
    else           phase_light = 8'(1) << (4'(p) - 4'd1);
  endfunction

  // Segments {dp,g,f,e,d,c,b,a}; anything above 9 renders blank.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/wash_seq_seg_scan4.sv
// Four-digit 7-segment multiplexer: rotates digits 3,2,1,0 every SCAN_DIV cycles.
module seg_scan4
  import wash_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] dig3,
  input  logic [3:0] dig2,
  input  logic [3:0] dig1,
  input  logic [3:0] dig0,
  output logic [7:0] led,
  output logic [3:0] ena
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       slot_q, slot_d;
  logic [7:0]       led_q, led_d;
  logic [3:0]       ena_q, ena_d;
  logic [3:0]       code_c;

  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    led_d  = '0;
    ena_d  = '0;
    code_c = BLANK_CODE;
    if (clr || !en) begin
      cnt_d  = '0;
      slot_d = '0;
    end else begin
      // Slot 0 drives the leftmost digit.
      case (slot_q)
        2'd0:    begin code_c = dig3; ena_d = 4'b1000; end
        2'd1:    begin code_c = dig2; ena_d = 4'b0100; end
        2'd2:    begin code_c = dig1; ena_d = 4'b0010; end
        default: begin code_c = dig0; ena_d = 4'b0001; end
      endcase
      led_d = seg7(code_c);
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        slot_d = slot_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      slot_q <= '0;
      led_q  <= '0;
      ena_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      led_q  <= led_d;
      ena_q  <= ena_d;
    end
  end

  assign led = led_q;
  assign ena = ena_q;

endmodule

// File: rtl/wash_seq.sv
// Wash-phase sequencer: fill/wash/drain/rinse/spin timed on a 1 s tick, drives lights and display.
// Build with WASH_SEQ_PAUSE_EN to let m_pos pause/resume a running phase.
module wash_seq
  import wash_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned SCAN_DIV      = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       on,
  input  logic [1:0] mode,
  input  logic       m_pos,
  output logic [7:0] led,
  output logic [3:0] ena,
  output logic [7:0] st_light,
  output logic [7:0] wt_light,
  output logic       next
);

  localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

  phase_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [SEC_W-1:0]   rem_q, rem_d;
  logic [LVL_W-1:0]   wt_q, wt_d;
  logic [7:0]         st_q, st_d;
  logic               next_q, next_d;
  logic               tick_c;
  logic               run_c;

`ifdef WASH_SEQ_PAUSE_EN
  logic               pause_q, pause_d;
  logic               blink_q, blink_d;
  logic [TICK_W-1:0]  frozen_q, frozen_d;
`else
  logic               unused_m_pos;
  assign unused_m_pos = m_pos;
`endif

  // Phase sequencing, tick timing and water-level thermometer.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tick_d  = tick_q;
    rem_d   = rem_q;
    wt_d    = wt_q;
    tick_c  = 1'b0;
    run_c   = 1'b1;
`ifdef WASH_SEQ_PAUSE_EN
    pause_d  = pause_q;
    blink_d  = blink_q;
    frozen_d = frozen_q;
    run_c    = !pause_q;
`endif
    if (!on) begin
      state_d = IDLE;
      tick_d  = '0;
      rem_d   = '0;
      wt_d    = '0;
`ifdef WASH_SEQ_PAUSE_EN
      pause_d  = 1'b0;
      blink_d  = 1'b0;
      frozen_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          mode_d  = mode;
          state_d = first_live(FILL, mode);
          tick_d  = '0;
          rem_d   = phase_secs(state_d, mode);
          wt_d    = '0;
        end
        DONE: begin
          tick_d = '0;
        end
        default: begin
          tick_c = (tick_q == TICK_LAST);
          tick_d = tick_c ? '0 : tick_q + TICK_W'(1);
          if (run_c && tick_c) begin
            if (state_q == FILL || state_q == RFILL) begin
              wt_d = {wt_q[LVL_W-2:0], 1'b1};
            end else if (state_q == DRAIN || state_q == RDRAIN) begin
              wt_d = {1'b0, wt_q[LVL_W-1:1]};
            end
            rem_d = rem_q - SEC_W'(1);
            if (rem_q == SEC_W'(1)) begin
              state_d = first_live(phase_t'(4'(state_q) + 4'd1), mode_q);
              tick_d  = '0;
              rem_d   = phase_secs(state_d, mode_q);
            end
          end
`ifdef WASH_SEQ_PAUSE_EN
          // While paused the tick counter only paces the blink; the fine count is parked.
          if (pause_q) begin
            if (tick_c) blink_d = !blink_q;
            if (m_pos) begin
              pause_d = 1'b0;
              blink_d = 1'b0;
              tick_d  = frozen_q;
            end
          end else if (m_pos && state_d != DONE) begin
            pause_d  = 1'b1;
            blink_d  = 1'b0;
            frozen_d = tick_d;
          end
`endif
        end
      endcase
    end
    if (state_d == DONE) wt_d = '0;
    st_d = phase_light(state_d);
`ifdef WASH_SEQ_PAUSE_EN
    if (pause_d && blink_d) st_d = '0;
`endif
    next_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      tick_q  <= '0;
      rem_q   <= '0;
      wt_q    <= '0;
      st_q    <= '0;
      next_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      rem_q   <= rem_d;
      wt_q    <= wt_d;
      st_q    <= st_d;
      next_q  <= next_d;
    end
  end

`ifdef WASH_SEQ_PAUSE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pause_q  <= 1'b0;
      blink_q  <= 1'b0;
      frozen_q <= '0;
    end else begin
      pause_q  <= pause_d;
      blink_q  <= blink_d;
      frozen_q <= frozen_d;
    end
  end
`endif

  // Digit 3 shows the phase code (enum value), digit 2 blank, digits 1:0 remaining seconds.
  seg_scan4 #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .clr  (!on),
    .en   (state_q != IDLE),
    .dig3 (4'(state_q)),
    .dig2 (BLANK_CODE),
    .dig1 (4'(rem_q / SEC_W'(10))),
    .dig0 (4'(rem_q % SEC_W'(10))),
    .led  (led),
    .ena  (ena)
  );

  assign st_light = st_q;
  assign wt_light = wt_q;
  assign next     = next_q;

endmodule
